// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data memory arbiter with alignment/range checks and load formatting (optional DMEM_ARB_RR_EN)
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_WORDS  = 30001,
    parameter int WIDX_WIDTH = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  p0_req_valid,
    output logic                  p0_req_ready,
    input  logic                  p0_req_we,
    input  logic [1:0]            p0_req_size,
    input  logic                  p0_req_unsigned,
    input  logic [ADDR_WIDTH-1:0] p0_req_addr,
    input  logic [31:0]           p0_req_wdata,
    output logic                  p0_rsp_valid,
    output logic                  p0_rsp_err,
    output logic [31:0]           p0_rsp_rdata,
    input  logic                  p1_req_valid,
    output logic                  p1_req_ready,
    input  logic                  p1_req_we,
    input  logic [1:0]            p1_req_size,
    input  logic                  p1_req_unsigned,
    input  logic [ADDR_WIDTH-1:0] p1_req_addr,
    input  logic [31:0]           p1_req_wdata,
    output logic                  p1_rsp_valid,
    output logic                  p1_rsp_err,
    output logic [31:0]           p1_rsp_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [WIDX_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_wstrb,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [ADDR_WIDTH-1:0] MEM_WORDS_W = ADDR_WIDTH'(MEM_WORDS);

    state_t                state, state_next;
    logic                  grant0, grant1, accept;
    logic                  sel_we, sel_uns, sel_err;
    logic [1:0]            sel_size;
    logic [ADDR_WIDTH-1:0] sel_addr, sel_widx;
    logic [31:0]           sel_wdata, pos_wdata, fmt_rdata;
    logic [3:0]            pos_wstrb;
    logic                  lat_port, lat_we, lat_uns, lat_err, last_grant;
    logic [1:0]            lat_size, lat_off;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;

    // Arbitration: grants only exist in IDLE and out of reset, so ready drops at once on rst_n
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE && rst_n) begin
`ifdef DMEM_ARB_RR_EN
            if (p0_req_valid && p1_req_valid) begin
                grant0 = last_grant;
                grant1 = !last_grant;
            end else begin
                grant0 = p0_req_valid;
                grant1 = p1_req_valid;
            end
`else
            grant0 = p0_req_valid;
            grant1 = p1_req_valid && !p0_req_valid;
`endif
        end
    end

    // Mux the granted request and classify it; half at offset 3 is caught by the addr[0] test
    always_comb begin
        accept    = grant0 || grant1;
        sel_we    = grant1 ? p1_req_we       : p0_req_we;
        sel_size  = grant1 ? p1_req_size     : p0_req_size;
        sel_uns   = grant1 ? p1_req_unsigned : p0_req_unsigned;
        sel_addr  = grant1 ? p1_req_addr     : p0_req_addr;
        sel_wdata = grant1 ? p1_req_wdata    : p0_req_wdata;
        sel_widx  = sel_addr >> 2;
        sel_err   = (sel_size == 2'd3)
                 || (sel_size == 2'd1 && sel_addr[0])
                 || (sel_size == 2'd2 && sel_addr[1:0] != 2'd0)
                 || (sel_widx >= MEM_WORDS_W);
    end

    // Lane strobes and replicated write data (big-endian lanes: offset 0 is bits 31:24)
    always_comb begin
        case (sel_size)
            2'd0: begin
                pos_wstrb = 4'b1000 >> sel_addr[1:0];
                pos_wdata = {4{sel_wdata[7:0]}};
            end
            2'd1: begin
                pos_wstrb = sel_addr[1] ? 4'b0011 : 4'b1100;
                pos_wdata = {2{sel_wdata[15:0]}};
            end
            default: begin
                pos_wstrb = 4'b1111;
                pos_wdata = sel_wdata;
            end
        endcase
        if (!sel_we) begin
            pos_wstrb = 4'b0000;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: every accepted request, legal or not, takes exactly IDLE->WAIT->RESP
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = WAIT;
            WAIT:    state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode: handshake and memory strobes, memory is touched only by legal accepts
    always_comb begin
        p0_req_ready = grant0;
        p1_req_ready = grant1;
        mem_en       = accept && !sel_err;
        mem_we       = mem_en && sel_we;
        mem_addr     = mem_en ? sel_addr[WIDX_WIDTH+1:2] : '0;
        mem_wstrb    = mem_en ? pos_wstrb : 4'b0000;
        mem_wdata    = mem_en ? pos_wdata : 32'd0;
    end

    // Capture the transaction context on accept; last_grant tracks the most recent winner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_port   <= 1'b0;
            lat_we     <= 1'b0;
            lat_size   <= 2'd0;
            lat_uns    <= 1'b0;
            lat_off    <= 2'd0;
            lat_err    <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            if (accept) begin
                lat_port <= grant1;
                lat_we   <= sel_we;
                lat_size <= sel_size;
                lat_uns  <= sel_uns;
                lat_off  <= sel_addr[1:0];
                lat_err  <= sel_err;
            end
            last_grant <= accept ? grant1 : last_grant;
        end
    end

    // Load formatting: pick the lane by latched offset, then sign- or zero-extend
    always_comb begin
        case (lat_off)
            2'd0:    rd_byte = mem_rdata[31:24];
            2'd1:    rd_byte = mem_rdata[23:16];
            2'd2:    rd_byte = mem_rdata[15:8];
            default: rd_byte = mem_rdata[7:0];
        endcase
        rd_half = lat_off[1] ? mem_rdata[15:0] : mem_rdata[31:16];
        case (lat_size)
            2'd0:    fmt_rdata = lat_uns ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            2'd1:    fmt_rdata = lat_uns ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: fmt_rdata = mem_rdata;
        endcase
        if (lat_we || lat_err) begin
            fmt_rdata = 32'd0;
        end
    end

    // Response registers: loaded in WAIT so the pulse appears in RESP and lasts one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_rsp_valid <= 1'b0;
            p0_rsp_err   <= 1'b0;
            p0_rsp_rdata <= 32'd0;
            p1_rsp_valid <= 1'b0;
            p1_rsp_err   <= 1'b0;
            p1_rsp_rdata <= 32'd0;
        end else begin
            p0_rsp_valid <= 1'b0;
            p0_rsp_err   <= 1'b0;
            p1_rsp_valid <= 1'b0;
            p1_rsp_err   <= 1'b0;
            if (state == WAIT) begin
                if (lat_port) begin
                    p1_rsp_valid <= 1'b1;
                    p1_rsp_err   <= lat_err;
                    p1_rsp_rdata <= fmt_rdata;
                end else begin
                    p0_rsp_valid <= 1'b1;
                    p0_rsp_err   <= lat_err;
                    p0_rsp_rdata <= fmt_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed scoreboard bench for dmem_arbiter
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        p0_req_valid = 0, p0_req_ready, p0_req_we = 0, p0_req_unsigned = 0;
    logic [1:0]  p0_req_size = 0;
    logic [31:0] p0_req_addr = 0, p0_req_wdata = 0;
    logic        p0_rsp_valid, p0_rsp_err;
    logic [31:0] p0_rsp_rdata;
    logic        p1_req_valid = 0, p1_req_ready, p1_req_we = 0, p1_req_unsigned = 0;
    logic [1:0]  p1_req_size = 0;
    logic [31:0] p1_req_addr = 0, p1_req_wdata = 0;
    logic        p1_rsp_valid, p1_rsp_err;
    logic [31:0] p1_rsp_rdata;
    logic        mem_en, mem_we;
    logic [14:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 0;

    typedef struct {
        int          port;
        logic        err;
        logic [31:0] rdata;
    } exp_t;
    exp_t q[$];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
        .p0_req_size(p0_req_size), .p0_req_unsigned(p0_req_unsigned), .p0_req_addr(p0_req_addr),
        .p0_req_wdata(p0_req_wdata), .p0_rsp_valid(p0_rsp_valid), .p0_rsp_err(p0_rsp_err),
        .p0_rsp_rdata(p0_rsp_rdata),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
        .p1_req_size(p1_req_size), .p1_req_unsigned(p1_req_unsigned), .p1_req_addr(p1_req_addr),
        .p1_req_wdata(p1_req_wdata), .p1_rsp_valid(p1_rsp_valid), .p1_rsp_err(p1_rsp_err),
        .p1_rsp_rdata(p1_rsp_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pops the oldest expectation once a response pulse shows up; latency counted from the accept edge
    task automatic wait_rsp();
        int   n = 0;
        bit   got = 0;
        exp_t e;
        for (int i = 1; i <= 5 && !got; i++) begin
            @(negedge clk);
            if (p0_rsp_valid || p1_rsp_valid) begin
                got = 1;
                n = i;
            end
        end
        chk("rsp_seen", 32'(got), 32'd1);
        if (got && q.size() > 0) begin
            e = q.pop_front();
            chk("rsp_latency", 32'(n), 32'd2);
            chk("rsp_port", 32'(p1_rsp_valid ? 1 : 0), 32'(e.port));
            chk("rsp_both", 32'(p0_rsp_valid && p1_rsp_valid), 32'd0);
            chk("rsp_err", 32'(e.port == 1 ? p1_rsp_err : p0_rsp_err), 32'(e.err));
            chk("rsp_rdata", e.port == 1 ? p1_rsp_rdata : p0_rsp_rdata, e.rdata);
        end
    endtask

    task automatic req(input int port, input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rd,
                       input logic exp_en, input logic [14:0] exp_addr, input logic [3:0] exp_strb,
                       input logic [31:0] exp_wdata, input logic exp_err, input logic [31:0] exp_rdata);
        exp_t e;
        @(negedge clk);
        if (port == 1) begin
            p1_req_we = we; p1_req_size = size; p1_req_unsigned = uns;
            p1_req_addr = addr; p1_req_wdata = wdata; p1_req_valid = 1;
        end else begin
            p0_req_we = we; p0_req_size = size; p0_req_unsigned = uns;
            p0_req_addr = addr; p0_req_wdata = wdata; p0_req_valid = 1;
        end
        mem_rdata = 32'h0;
        #1;
        chk("req_ready", 32'(port == 1 ? p1_req_ready : p0_req_ready), 32'd1);
        chk("mem_en", 32'(mem_en), 32'(exp_en));
        if (exp_en) begin
            chk("mem_we", 32'(mem_we), 32'(we));
            chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
            chk("mem_wstrb", 32'(mem_wstrb), 32'(exp_strb));
            if (we) chk("mem_wdata", mem_wdata, exp_wdata);
        end
        e.port = port; e.err = exp_err; e.rdata = exp_rdata;
        q.push_back(e);
        @(posedge clk);
        #1;
        p0_req_valid = 0;
        p1_req_valid = 0;
        mem_rdata = rd;
        wait_rsp();
    endtask

    initial begin
        bit   seen;
        exp_t e;

        p0_req_valid = 1;
        #2;
        chk("rst_p0_ready", 32'(p0_req_ready), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_rsp_valid", 32'({p0_rsp_valid, p1_rsp_valid}), 32'd0);
        chk("rst_rsp_rdata", p0_rsp_rdata | p1_rsp_rdata, 32'd0);
        p0_req_valid = 0;
        @(negedge clk);
        rst_n = 1;

        //   port we size uns addr            wdata          rd             en addr    strb     wdata          err rdata
        req(0, 1, 2'd2, 0, 32'h10,         32'hDEADBEEF, 32'h0,        1, 15'd4,  4'b1111, 32'hDEADBEEF, 0, 32'h0);
        req(0, 0, 2'd0, 0, 32'h11,         32'h0,        32'hDE80BEEF, 1, 15'd4,  4'b0000, 32'h0,        0, 32'hFFFFFF80);
        req(0, 0, 2'd0, 1, 32'h11,         32'h0,        32'hDE80BEEF, 1, 15'd4,  4'b0000, 32'h0,        0, 32'h00000080);
        req(1, 1, 2'd1, 0, 32'h22,         32'h1234,     32'h0,        1, 15'd8,  4'b0011, 32'h12341234, 0, 32'h0);
        req(1, 0, 2'd1, 0, 32'h22,         32'h0,        32'hAAAA1234, 1, 15'd8,  4'b0000, 32'h0,        0, 32'h00001234);
        req(0, 0, 2'd1, 0, 32'h20,         32'h0,        32'h8001AAAA, 1, 15'd8,  4'b0000, 32'h0,        0, 32'hFFFF8001);
        req(0, 0, 2'd1, 1, 32'h20,         32'h0,        32'h8001AAAA, 1, 15'd8,  4'b0000, 32'h0,        0, 32'h00008001);
        req(1, 0, 2'd0, 0, 32'h2F,         32'h0,        32'h112233F4, 1, 15'd11, 4'b0000, 32'h0,        0, 32'hFFFFFFF4);
        req(0, 1, 2'd0, 0, 32'h07,         32'h000000A5, 32'h0,        1, 15'd1,  4'b0001, 32'hA5A5A5A5, 0, 32'h0);
        req(0, 1, 2'd0, 0, 32'h04,         32'h0000003C, 32'h0,        1, 15'd1,  4'b1000, 32'h3C3C3C3C, 0, 32'h0);
        req(0, 0, 2'd2, 0, 32'h13,         32'h0,        32'h12345678, 0, 15'd0,  4'b0000, 32'h0,        1, 32'h0);
        req(1, 0, 2'd2, 0, 32'd120004,     32'h0,        32'h12345678, 0, 15'd0,  4'b0000, 32'h0,        1, 32'h0);
        req(1, 0, 2'd2, 0, 32'd120000,     32'h0,        32'hCAFEF00D, 1, 15'd30000, 4'b0000, 32'h0,     0, 32'hCAFEF00D);
        req(0, 0, 2'd1, 0, 32'h23,         32'h0,        32'h12345678, 0, 15'd0,  4'b0000, 32'h0,        1, 32'h0);
        req(0, 1, 2'd1, 0, 32'h21,         32'h5555,     32'h0,        0, 15'd0,  4'b0000, 32'h0,        1, 32'h0);
        req(1, 0, 2'd3, 0, 32'h40,         32'h0,        32'h12345678, 0, 15'd0,  4'b0000, 32'h0,        1, 32'h0);

        // Both ports requesting continuously: fixed priority keeps granting port 0
        p0_req_we = 0; p0_req_size = 2'd2; p0_req_unsigned = 0; p0_req_addr = 32'h0;
        p1_req_we = 0; p1_req_size = 2'd2; p1_req_unsigned = 0; p1_req_addr = 32'h4;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            p0_req_valid = 1;
            p1_req_valid = 1;
            #1;
            chk("arb_p0_ready", 32'(p0_req_ready), 32'd1);
            chk("arb_p1_ready", 32'(p1_req_ready), 32'd0);
            e.port = 0; e.err = 0; e.rdata = 32'h11223300 + 32'(t);
            q.push_back(e);
            @(posedge clk);
            #1;
            mem_rdata = 32'h11223300 + 32'(t);
            wait_rsp();
        end
        p0_req_valid = 0;
        p1_req_valid = 0;

        // Reset while in WAIT: everything clears without a clock edge and no response follows
        @(negedge clk);
        p0_req_we = 0; p0_req_size = 2'd2; p0_req_addr = 32'h8; p0_req_valid = 1;
        @(posedge clk);
        #1;
        p0_req_valid = 0;
        mem_rdata = 32'h77777777;
        @(negedge clk);
        p0_req_valid = 1;
        rst_n = 0;
        #1;
        chk("rstw_p0_ready", 32'(p0_req_ready), 32'd0);
        chk("rstw_mem_en", 32'(mem_en), 32'd0);
        chk("rstw_rsp_valid", 32'({p0_rsp_valid, p1_rsp_valid}), 32'd0);
        chk("rstw_rsp_rdata", p0_rsp_rdata, 32'd0);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (p0_rsp_valid || p1_rsp_valid) seen = 1;
        end
        chk("rstw_no_rsp", 32'(seen), 32'd0);
        p0_req_valid = 0;
        rst_n = 1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (p0_rsp_valid || p1_rsp_valid) seen = 1;
        end
        chk("rstw_no_late_rsp", 32'(seen), 32'd0);

        req(1, 1, 2'd2, 0, 32'h100, 32'h01020304, 32'h0, 1, 15'd64, 4'b1111, 32'h01020304, 0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
